// File: rtl/memory_access.sv
// Memory-access pipeline stage: turns the execute result into a load/store on a req/ack data port,
// stalls upstream while the transfer is outstanding and hands the finished status to writeback.
// Optional build macro: MEM_MISALIGN_TRAP_EN (adds the 'misaligned' output and traps misaligned
// accesses instead of forcing them aligned).

package memory_access_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      memory_read;
    logic      memory_write;
    mem_size_e memory_size;
    logic      memory_unsigned;
  } instruction_t;

  typedef struct packed {
    logic [31:0] value;
    logic        valid;
    logic [4:0]  target;
  } data_t;

  typedef struct packed {
    logic         valid;
    logic         ready;
    logic [31:0]  pc;
    instruction_t instruction;
    data_t        data;
    logic [31:0]  reg_rs1;
    logic [31:0]  reg_rs2;
  } stage_status_t;

endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_status_t    stage_in,
  output stage_status_t    stage_out,
  output logic             mem_req,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_byte_en,
  input  logic             mem_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             misaligned
`else
  input  logic [WIDTH-1:0] mem_rdata
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d;

  logic             mem_op, is_load;
  logic [1:0]       off, off_al;
  logic [WIDTH-1:0] rd_shift, rd_ext;

  assign mem_op  = stage_in.valid &&
                   (stage_in.instruction.memory_read || stage_in.instruction.memory_write);
  assign is_load = stage_in.instruction.memory_read && !stage_in.instruction.memory_write;
  assign off     = stage_in.data.value[1:0];

  // Lane alignment of the request: offset forced to the access size, enables and replicated data
  always_comb begin
    off_al      = 2'b00;
    mem_byte_en = 4'b1111;
    mem_wdata   = stage_in.reg_rs2;
    unique case (stage_in.instruction.memory_size)
      MemByte: begin
        off_al      = off;
        mem_byte_en = 4'b0001 << off;
        mem_wdata   = {4{stage_in.reg_rs2[7:0]}};
      end
      MemHalf: begin
        off_al      = {off[1], 1'b0};
        mem_byte_en = off[1] ? 4'b1100 : 4'b0011;
        mem_wdata   = {2{stage_in.reg_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_write = stage_in.instruction.memory_write;
  assign mem_addr  = {stage_in.data.value[WIDTH-1:2], 2'b00};

  // Load extraction: shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    rd_shift = mem_rdata >> {off_al, 3'b000};
    rd_ext   = rd_shift;
    unique case (stage_in.instruction.memory_size)
      MemByte: rd_ext = {{24{~stage_in.instruction.memory_unsigned & rd_shift[7]}},
                         rd_shift[7:0]};
      MemHalf: rd_ext = {{16{~stage_in.instruction.memory_unsigned & rd_shift[15]}},
                         rd_shift[15:0]};
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic is_misal;
  assign is_misal = (stage_in.instruction.memory_size == MemHalf) ? off[0] :
                    (stage_in.instruction.memory_size == MemByte) ? 1'b0 : (off != 2'b00);
`endif

  // Transfer FSM next state and stage outputs
  always_comb begin
    state_d         = state_q;
    load_d          = load_q;
    stage_out       = stage_in;
    stage_out.ready = 1'b1;
    mem_req         = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          stage_out.valid = 1'b0;
          stage_out.ready = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          if (is_misal) begin
            state_d = StDone;
          end else
`endif
          begin
            mem_req = 1'b1;
            if (mem_ack) begin
              load_d  = rd_ext;
              state_d = StDone;
            end else begin
              state_d = StBusy;
            end
          end
        end
      end
      StBusy: begin
        mem_req         = 1'b1;
        stage_out.valid = 1'b0;
        stage_out.ready = 1'b0;
        if (mem_ack) begin
          load_d  = rd_ext;
          state_d = StDone;
        end
      end
      StDone: begin
        stage_out.valid = 1'b1;
        if (is_load) begin
          stage_out.data.value = load_q;
          stage_out.data.valid = 1'b1;
        end else begin
          stage_out.data.valid  = 1'b0;
          stage_out.data.target = '0;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (is_misal) begin
          misaligned           = 1'b1;
          stage_out.data.valid = 1'b0;
        end
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset gates every handshake output so nothing leaks out while held
    if (!rst_n) begin
      mem_req         = 1'b0;
      stage_out.valid = 1'b0;
      stage_out.ready = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned      = 1'b0;
`endif
    end
  end

  // State and captured load data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus randomized loads, stores and
// pass-through ops, checked against a byte-lane reference model.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  stage_status_t stage_in, stage_out;
  logic          mem_req, mem_write, mem_ack;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_byte_en;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_access #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stage_in   (stage_in),
    .stage_out  (stage_out),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byte_en(mem_byte_en),
    .mem_ack    (mem_ack),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_rdata  (mem_rdata),
    .misaligned (misaligned)
`else
    .mem_rdata  (mem_rdata)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input mem_size_e s);
    return (s == MemByte) ? 1 : (s == MemHalf) ? 2 : 4;
  endfunction

  function automatic int model_off(input mem_size_e s, input logic [31:0] a);
    int n = nbytes(s);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic model_misal(input mem_size_e s, input logic [31:0] a);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input mem_size_e s, input logic [31:0] a);
    int v = ((1 << nbytes(s)) - 1) << model_off(s, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input mem_size_e s, input logic [31:0] rs2);
    logic [31:0] w;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) w[8*i+:8] = rs2[8*(i%n)+:8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input mem_size_e s, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(s);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
    logic [31:0] v = (rd >> (8 * model_off(s, a))) & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic rd, input logic wr, input mem_size_e sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] tgt);
    stage_in                             = '0;
    stage_in.valid                       = 1'b1;
    stage_in.ready                       = $urandom_range(0, 1);
    stage_in.pc                          = $urandom;
    stage_in.instruction.memory_read     = rd;
    stage_in.instruction.memory_write    = wr;
    stage_in.instruction.memory_size     = sz;
    stage_in.instruction.memory_unsigned = uns;
    stage_in.data.value                  = addr;
    stage_in.data.valid                  = 1'b1;
    stage_in.data.target                 = tgt;
    stage_in.reg_rs1                     = $urandom;
    stage_in.reg_rs2                     = rs2;
  endtask

  // Non-memory op: must pass straight through in the same cycle
  task automatic run_alu(input logic [31:0] value, input logic vld);
    drive(1'b0, 1'b0, MemWord, 1'b0, value, $urandom, 5'($urandom));
    stage_in.valid = vld;
    mem_ack        = $urandom_range(0, 1);
    @(negedge clk);
    check("alu_value", stage_out.data.value, value);
    check("alu_valid", stage_out.valid, vld);
    check("alu_ready", stage_out.ready, 1'b1);
    check("alu_req", mem_req, 1'b0);
    check("alu_pc", stage_out.pc, stage_in.pc);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // One memory op; delay = cycles between request cycle and the ack cycle
  task automatic run_mem(input logic rd, input logic wr, input mem_size_e sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] tgt,
                         input int delay, input logic [31:0] rdata);
    logic ld = rd && !wr;
    drive(rd, wr, sz, uns, addr, rs2, tgt);
`ifdef MEM_MISALIGN_TRAP_EN
    if (model_misal(sz, addr)) begin
      mem_ack = 1'b0;
      @(negedge clk);
      check("trap_req", mem_req, 1'b0);
      check("trap_ready0", stage_out.ready, 1'b0);
      check("trap_mis0", misaligned, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("trap_mis", misaligned, 1'b1);
      check("trap_valid", stage_out.valid, 1'b1);
      check("trap_dvalid", stage_out.data.valid, 1'b0);
      check("trap_req_done", mem_req, 1'b0);
      @(posedge clk); #1;
      return;
    end
`endif
    mem_ack   = (delay == 0);
    mem_rdata = (delay == 0) ? rdata : $urandom;
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      check("req", mem_req, 1'b1);
      check("write", mem_write, wr);
      check("addr", mem_addr, {addr[31:2], 2'b00});
      check("byte_en", mem_byte_en, model_be(sz, addr));
      if (wr) check("wdata", mem_wdata, model_wdata(sz, rs2));
      check("stall_ready", stage_out.ready, 1'b0);
      check("stall_valid", stage_out.valid, 1'b0);
      @(posedge clk); #1;
      mem_ack   = (c + 1 == delay);
      mem_rdata = (c + 1 == delay) ? rdata : $urandom;
    end
    // Stray ack in DONE must be ignored
    mem_ack   = $urandom_range(0, 1);
    mem_rdata = $urandom;
    @(negedge clk);
    check("done_valid", stage_out.valid, 1'b1);
    check("done_ready", stage_out.ready, 1'b1);
    check("done_req", mem_req, 1'b0);
    check("done_dvalid", stage_out.data.valid, ld);
    check("done_target", stage_out.data.target, ld ? tgt : 5'd0);
    if (ld) check("done_load", stage_out.data.value, model_load(sz, uns, addr, rdata));
`ifdef MEM_MISALIGN_TRAP_EN
    check("done_mis", misaligned, 1'b0);
`endif
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive(1'b1, 1'b0, MemWord, 1'b0, 32'h100, 32'h0, 5'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_valid", stage_out.valid, 1'b0);
    check("rst_ready", stage_out.ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    run_mem(1'b1, 1'b0, MemWord, 1'b0, 32'h100, 32'h0, 5'd7, 2, 32'hDEADBEEF);
    run_mem(1'b1, 1'b0, MemByte, 1'b0, 32'h103, 32'h0, 5'd4, 1, 32'h80112233);
    run_mem(1'b1, 1'b0, MemByte, 1'b1, 32'h103, 32'h0, 5'd4, 0, 32'h80112233);
    run_mem(1'b0, 1'b1, MemHalf, 1'b0, 32'h202, 32'h1234ABCD, 5'd9, 1, 32'h0);
    run_alu(32'h5, 1'b1);
    // Back-to-back memory ops with no idle gap in stimulus
    run_mem(1'b1, 1'b0, MemHalf, 1'b0, 32'h402, 32'h0, 5'd1, 0, 32'h8001_7FFF);
    run_mem(1'b1, 1'b0, MemHalf, 1'b1, 32'h400, 32'h0, 5'd2, 0, 32'h8001_7FFF);
`ifdef MEM_MISALIGN_TRAP_EN
    run_mem(1'b1, 1'b0, MemWord, 1'b0, 32'h102, 32'h0, 5'd1, 1, 32'h0);
`endif

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      int kind = $urandom_range(0, 3);
      if (kind == 0) begin
        run_alu($urandom, 1'($urandom_range(0, 1)));
      end else begin
        run_mem(kind == 1, kind != 1, mem_size_e'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 3), $urandom);
      end
    end

    // Reset while BUSY, then a stray ack must not complete anything
    drive(1'b1, 1'b0, MemWord, 1'b0, 32'h300, 32'h0, 5'd2);
    mem_ack = 1'b0;
    @(negedge clk);
    check("rb_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rb_rst_req", mem_req, 1'b0);
    check("rb_rst_valid", stage_out.valid, 1'b0);
    check("rb_rst_ready", stage_out.ready, 1'b0);
    @(posedge clk); #1;
    rst_n          = 1'b1;
    stage_in.valid = 1'b0;
    mem_ack        = 1'b1;
    mem_rdata      = 32'hCAFE_F00D;
    @(negedge clk);
    check("rb_idle_req", mem_req, 1'b0);
    check("rb_idle_ready", stage_out.ready, 1'b1);
    check("rb_idle_valid", stage_out.valid, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rb_after_ready", stage_out.ready, 1'b1);
    check("rb_after_valid", stage_out.valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
